cipher_tx_serializer: RTL

Streams the ASCON encryption result (1472-bit cipher wave plus 128-bit tag) out through the UART byte interface. It sits between the ASCON core (downstream of it) and the UART transmitter (upstream of it). It latches the full result on a start pulse, then emits it MSB-byte-first, one byte per UART load, pacing on the transmitter's busy flag. It reports completion with a one-cycle done pulse.

---
 rtl/uart_pkg.sv | 9 +
 rtl/tx_byte_handshake.sv | 42 ++++
 rtl/cipher_tx_serializer.sv | 117 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART-side constants and the cipher serializer state encoding.
package uart_pkg;
    localparam int NDBits       = 8;
    localparam int CIPHER_BYTES = 184;
    localparam int TAG_BYTES    = 16;
    localparam int FRAME_BYTES  = 200;

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_HI, WAIT_LO, DONE} tx_ser_state_t;
endpackage

// File: rtl/tx_byte_handshake.sv
// One-byte LOAD / WAIT_HI / WAIT_LO handshake against the UART busy flag.
module tx_byte_handshake (
    input  logic clock_i,
    input  logic reset_i,
    input  logic go_i,
    input  logic more_i,
    input  logic tx_busy_i,
    output logic load_o,
    output logic in_load_o,
    output logic idle_o,
    output logic byte_done_o
);
    import uart_pkg::*;

    tx_ser_state_t state_q;
    logic          load_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            load_q  <= 1'b0;
        end else begin
            load_q <= 1'b0;
            case (state_q)
                IDLE:    if (go_i) state_q <= LOAD;
                LOAD: begin
                    load_q  <= 1'b1;
                    state_q <= WAIT_HI;
                end
                WAIT_HI: if (tx_busy_i) state_q <= WAIT_LO;
                // Chain straight into the next LOAD so bytes are not separated by an idle cycle.
                WAIT_LO: if (!tx_busy_i) state_q <= more_i ? LOAD : IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign load_o      = load_q;
    assign in_load_o   = (state_q == LOAD);
    assign idle_o      = (state_q == IDLE);
    assign byte_done_o = (state_q == WAIT_LO) && !tx_busy_i;
endmodule

// File: rtl/cipher_tx_serializer.sv
// Latches cipher+tag on start and streams it MSB-byte-first to the UART.
// Optional TX_CHECKSUM_EN appends an XOR checksum byte after the tag.
module cipher_tx_serializer
    import uart_pkg::*;
#(
    parameter int CIPHER_W = 1472,
    parameter int TAG_W    = 128
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic [CIPHER_W-1:0] cipher_i,
    input  logic [TAG_W-1:0]    tag_i,
    input  logic                tx_busy_i,
    output logic [NDBits-1:0]   tx_byte_o,
    output logic                load_o,
    output logic                busy_o,
    output logic                done_o
);
    localparam int SHREG_W = CIPHER_W + TAG_W;
    localparam int NBYTES  = SHREG_W / NDBits;
`ifdef TX_CHECKSUM_EN
    localparam int LAST_IDX = NBYTES;
`else
    localparam int LAST_IDX = NBYTES - 1;
`endif

    logic [SHREG_W-1:0] shreg_q, shreg_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [NDBits-1:0]  tx_byte_q, tx_byte_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               accept, more, hs_in_load, hs_idle, hs_byte_done;
    logic [NDBits-1:0]  cur_byte;

    // done_q covers the DONE cycle, so a start arriving then is dropped.
    assign accept = start_i && hs_idle && !done_q;
    assign more   = (cnt_q != 8'(LAST_IDX));

    tx_byte_handshake u_hs (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .go_i        (accept),
        .more_i      (more),
        .tx_busy_i   (tx_busy_i),
        .load_o      (load_o),
        .in_load_o   (hs_in_load),
        .idle_o      (hs_idle),
        .byte_done_o (hs_byte_done)
    );

`ifdef TX_CHECKSUM_EN
    logic [NDBits-1:0] csum_q, csum_d;

    assign cur_byte = (cnt_q == 8'(NBYTES)) ? csum_q : shreg_q[SHREG_W-1 -: NDBits];

    always_comb begin
        csum_d = csum_q;
        if (accept)
            csum_d = '0;
        else if (hs_in_load && (cnt_q != 8'(NBYTES)))
            csum_d = csum_q ^ cur_byte;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) csum_q <= '0;
        else         csum_q <= csum_d;
    end
`else
    assign cur_byte = shreg_q[SHREG_W-1 -: NDBits];
`endif

    always_comb begin
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        tx_byte_d = tx_byte_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        if (accept) begin
            shreg_d = {cipher_i, tag_i};
            cnt_d   = '0;
        end
        if (hs_in_load) begin
            tx_byte_d = cur_byte;
            busy_d    = 1'b1;
        end
        if (hs_byte_done) begin
            if (more) begin
                shreg_d = shreg_q << NDBits;
                cnt_d   = cnt_q + 8'd1;
            end else begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            shreg_q   <= '0;
            cnt_q     <= '0;
            tx_byte_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            tx_byte_q <= tx_byte_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tx_byte_o = tx_byte_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
endmodule
